// File: rtl/uart_pkg.sv
// Shared UART definitions for the echo link: frame constants, state enums and
// the bit-period helper used by both the host and the reusable receiver core.
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;
    localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

    typedef enum logic [1:0] {
        HOST_IDLE,
        HOST_SEND,
        HOST_WAIT_ECHO,
        HOST_REPORT
    } host_state_e;

    typedef enum logic [1:0] {
        RX_HUNT,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    function automatic int clks_per_bit(input int clkFreq, input int baudRate);
        return clkFreq / baudRate;
    endfunction

endpackage

// File: rtl/uart_echo_host_if.sv
// Request/response bundle of the echo host: byte request (valid/ready) and
// the single-cycle response pulse with its result flags.
interface uart_echo_host_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 rsp_valid;
    logic [DATA_BITS-1:0] rsp_data;
    logic                 rsp_match;
    logic                 rsp_frame_err;
    logic                 rsp_timeout;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rsp_valid, rsp_data, rsp_match, rsp_frame_err, rsp_timeout
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rsp_valid, rsp_data, rsp_match, rsp_frame_err, rsp_timeout
    );

endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchronizer plus mid-bit deserializer, 8N1 LSB first.
// Only hunts for a start bit while arm_i is high; dropping arm_i aborts any frame.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arm_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 done_o,
    output logic                 frame_err_o,
    output logic                 busy_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           bitIdx_q, bitIdx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 done_q, done_d;
    logic                 frameErr_q, frameErr_d;
    logic                 sync1_q, sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= RX_HUNT;
            cnt_q      <= '0;
            bitIdx_q   <= '0;
            shift_q    <= '0;
            done_q     <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            sync1_q    <= rx_i;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitIdx_q   <= bitIdx_d;
            shift_q    <= shift_d;
            done_q     <= done_d;
            frameErr_q <= frameErr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bitIdx_d   = bitIdx_q;
        shift_d    = shift_q;
        done_d     = 1'b0;
        frameErr_d = frameErr_q;
        if (!arm_i) begin
            state_d = RX_HUNT;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                RX_HUNT: begin
                    if (!sync2_q) begin
                        state_d = RX_START;
                        cnt_d   = '0;
                    end
                end
                RX_START: begin
                    // Line back high at the start-bit centre means it was a glitch.
                    if (cnt_q == HALF_LAST) begin
                        cnt_d    = '0;
                        bitIdx_d = '0;
                        state_d  = sync2_q ? RX_HUNT : RX_DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d   = '0;
                        shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
                        if (bitIdx_q == IDX_LAST) state_d = RX_STOP;
                        else                      bitIdx_d = bitIdx_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d      = '0;
                        done_d     = 1'b1;
                        frameErr_d = !sync2_q;
                        state_d    = RX_HUNT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = RX_HUNT;
            endcase
        end
    end

    assign data_o      = shift_q;
    assign done_o      = done_q;
    assign frame_err_o = frameErr_q;
    assign busy_o      = (state_q != RX_HUNT);

endmodule

// File: rtl/uart_echo_host.sv
// Host end of the UART echo link: sends one byte, captures the echo and reports
// match / mismatch / framing error / timeout. UART_ECHO_HOST_STATS_EN enables err_count.
module uart_echo_host
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD_RATE    = 115_200,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic              clk,
    input  logic              rst,
    uart_echo_host_if.slave   bus,
    output logic              tx_o,
    input  logic              rx_i,
    output logic [15:0]       err_count_o
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int TO_LIMIT     = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int TO_W         = $clog2(TO_LIMIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TO_LIMIT - 1);
    localparam logic [3:0]       FRAME_LAST = 4'(FRAME_BITS - 1);

    host_state_e           state_q, state_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic [3:0]            bitIdx_q, bitIdx_d;
    logic [CNT_W-1:0]      clkCnt_q, clkCnt_d;
    logic [TO_W-1:0]       toCnt_q, toCnt_d;
    logic                  txBit_q, txBit_d;
    logic                  gotEcho_q, gotEcho_d;
    logic [DATA_BITS-1:0]  rspData_q, rspData_d;
    logic                  rspMatch_q, rspMatch_d;
    logic                  rspFrameErr_q, rspFrameErr_d;
    logic                  rspTimeout_q, rspTimeout_d;

    logic                  rxArm, rxDone, rxFrameErr, rxBusy, rspValid;
    logic [DATA_BITS-1:0]  rxData;

    assign rxArm = (state_q != HOST_IDLE);

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk         (clk),
        .rst         (rst),
        .arm_i       (rxArm),
        .rx_i        (rx_i),
        .data_o      (rxData),
        .done_o      (rxDone),
        .frame_err_o (rxFrameErr),
        .busy_o      (rxBusy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HOST_IDLE;
            frame_q       <= '1;
            bitIdx_q      <= '0;
            clkCnt_q      <= '0;
            toCnt_q       <= '0;
            txBit_q       <= 1'b1;
            gotEcho_q     <= 1'b0;
            rspData_q     <= '0;
            rspMatch_q    <= 1'b0;
            rspFrameErr_q <= 1'b0;
            rspTimeout_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_q       <= frame_d;
            bitIdx_q      <= bitIdx_d;
            clkCnt_q      <= clkCnt_d;
            toCnt_q       <= toCnt_d;
            txBit_q       <= txBit_d;
            gotEcho_q     <= gotEcho_d;
            rspData_q     <= rspData_d;
            rspMatch_q    <= rspMatch_d;
            rspFrameErr_q <= rspFrameErr_d;
            rspTimeout_q  <= rspTimeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        frame_d       = frame_q;
        bitIdx_d      = bitIdx_q;
        clkCnt_d      = clkCnt_q;
        toCnt_d       = toCnt_q;
        txBit_d       = txBit_q;
        gotEcho_d     = gotEcho_q;
        rspData_d     = rspData_q;
        rspMatch_d    = rspMatch_q;
        rspFrameErr_d = rspFrameErr_q;
        rspTimeout_d  = rspTimeout_q;
        // An echo can complete while our own stop bit is still on the line, so capture it in SEND too.
        if (rxDone && (state_q == HOST_SEND || state_q == HOST_WAIT_ECHO)) begin
            rspData_d     = rxData;
            rspFrameErr_d = rxFrameErr;
            rspMatch_d    = !rxFrameErr && (rxData == frame_q[DATA_BITS:1]);
            rspTimeout_d  = 1'b0;
        end
        unique case (state_q)
            HOST_IDLE: begin
                txBit_d = 1'b1;
                if (bus.tx_valid) begin
                    frame_d   = {1'b1, bus.tx_data, 1'b0};
                    bitIdx_d  = '0;
                    clkCnt_d  = '0;
                    txBit_d   = 1'b0;
                    gotEcho_d = 1'b0;
                    state_d   = HOST_SEND;
                end
            end
            HOST_SEND: begin
                if (rxDone) gotEcho_d = 1'b1;
                if (clkCnt_q == BIT_LAST) begin
                    clkCnt_d = '0;
                    if (bitIdx_q == FRAME_LAST) begin
                        toCnt_d = '0;
                        state_d = HOST_WAIT_ECHO;
                    end else begin
                        bitIdx_d = bitIdx_q + 4'd1;
                        txBit_d  = frame_q[bitIdx_q + 4'd1];
                    end
                end else begin
                    clkCnt_d = clkCnt_q + 1'b1;
                end
            end
            HOST_WAIT_ECHO: begin
                // Completed frame takes priority over an expiring timeout.
                if (rxDone || gotEcho_q) begin
                    state_d = HOST_REPORT;
                end else if (!rxBusy) begin
                    if (toCnt_q == TO_LAST) begin
                        rspData_d     = '0;
                        rspMatch_d    = 1'b0;
                        rspFrameErr_d = 1'b0;
                        rspTimeout_d  = 1'b1;
                        state_d       = HOST_REPORT;
                    end else begin
                        toCnt_d = toCnt_q + 1'b1;
                    end
                end
            end
            HOST_REPORT: state_d = HOST_IDLE;
            default:     state_d = HOST_IDLE;
        endcase
    end

    assign rspValid          = (state_q == HOST_REPORT);
    assign bus.tx_ready      = (state_q == HOST_IDLE) && !rst;
    assign bus.rsp_valid     = rspValid;
    assign bus.rsp_data      = rspValid ? rspData_q : '0;
    assign bus.rsp_match     = rspValid && rspMatch_q;
    assign bus.rsp_frame_err = rspValid && rspFrameErr_q;
    assign bus.rsp_timeout   = rspValid && rspTimeout_q;
    assign tx_o              = txBit_q;

`ifdef UART_ECHO_HOST_STATS_EN
    logic [15:0] errCount_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            errCount_q <= '0;
        end else if (rspValid && !rspMatch_q && (errCount_q != 16'hFFFF)) begin
            errCount_q <= errCount_q + 16'd1;
        end
    end

    assign err_count_o = errCount_q;
`else
    assign err_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_uart_echo_host.sv
// Self-checking bench for uart_echo_host at 10 clocks per bit: directed link scenarios
// plus randomized transactions checked against a frame-level reference model.
module tb_uart_echo_host;
    import uart_pkg::*;

    localparam int CLK_FREQ       = 1_000_000;
    localparam int BAUD_RATE      = 100_000;
    localparam int TIMEOUT_BITS   = 20;
    localparam int CPB            = CLK_FREQ / BAUD_RATE;
    localparam int SEND_CYCLES    = 10 * CPB;
    localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CPB;
`ifdef UART_ECHO_HOST_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        bit          found;
        int          lat;
        logic [7:0]  data;
        logic        match;
        logic        fe;
        logic        to;
        logic        readyAt;
        logic        readyNext;
        logic [15:0] err;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        txPin;
    logic        rxPin;
    logic        rxDrive = 1'b1;
    logic        loopEn = 1'b0;
    logic [15:0] errCount;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          errExp = 0;

    uart_echo_host_if bus();

    uart_echo_host #(
        .CLK_FREQ     (CLK_FREQ),
        .BAUD_RATE    (BAUD_RATE),
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .tx_o        (txPin),
        .rx_i        (rxPin),
        .err_count_o (errCount)
    );

    assign rxPin = loopEn ? txPin : rxDrive;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected err_count for a given number of non-match responses since reset.
    function automatic logic [15:0] expErr(input int n);
        return STATS ? ((n > 65535) ? 16'hFFFF : 16'(n)) : 16'h0000;
    endfunction

    task automatic waitUntil(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] d, output int acceptCyc, output bit ok);
        ok = 1'b0;
        acceptCyc = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.tx_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            bus.tx_data  = d;
            bus.tx_valid = 1'b1;
            @(negedge clk);
            acceptCyc    = cyc;
            bus.tx_valid = 1'b0;
        end
    endtask

    task automatic driveEcho(input logic [7:0] d, input logic stopBit, input int startCyc);
        waitUntil(startCyc);
        rxDrive = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxDrive = d[i];
            repeat (CPB) @(negedge clk);
        end
        rxDrive = stopBit;
        repeat (CPB) @(negedge clk);
        rxDrive = 1'b1;
    endtask

    task automatic waitRsp(input int limit, output obs_t o);
        o = '{found: 1'b0, lat: 0, data: 8'h00, match: 1'b0, fe: 1'b0, to: 1'b0,
              readyAt: 1'b0, readyNext: 1'b0, err: 16'h0000};
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                o.found   = 1'b1;
                o.lat     = cyc;
                o.data    = bus.rsp_data;
                o.match   = bus.rsp_match;
                o.fe      = bus.rsp_frame_err;
                o.to      = bus.rsp_timeout;
                o.readyAt = bus.tx_ready;
                @(negedge clk);
                o.readyNext = bus.tx_ready;
                o.err       = errCount;
                break;
            end
        end
    endtask

    task automatic runEcho(input logic [7:0] sent, input bit doEcho, input logic [7:0] echoByte,
                           input logic stopBit, input int startOff, input int glitchOff,
                           output obs_t o);
        int  a;
        bit  ok;
        applyStimulus(sent, a, ok);
        if (!ok) begin
            o = '{found: 1'b0, lat: 0, data: 8'h00, match: 1'b0, fe: 1'b0, to: 1'b0,
                  readyAt: 1'b0, readyNext: 1'b0, err: 16'h0000};
            return;
        end
        fork
            begin
                if (glitchOff > 0) begin
                    waitUntil(a + glitchOff);
                    rxDrive = 1'b0;
                    repeat (4) @(negedge clk);
                    rxDrive = 1'b1;
                end
                if (doEcho) driveEcho(echoByte, stopBit, a + startOff);
            end
            waitRsp(700, o);
        join
        o.lat = o.lat - a;
    endtask

    task automatic test_reset();
        $display("[TB] reset state");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (txPin !== 1'b1) begin bad++; $display("[TB] FAIL reset_tx: got %b want 1", txPin); end
        total++; if (bus.tx_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready: got %b want 0", bus.tx_ready); end
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        total++; if (errCount !== 16'h0000) begin bad++; $display("[TB] FAIL reset_err_count: got %h want 0000", errCount); end
        rst = 1'b0;
        errExp = 0;
        @(negedge clk);
        total++; if (bus.tx_ready !== 1'b1) begin bad++; $display("[TB] FAIL idle_ready: got %b want 1", bus.tx_ready); end
    endtask

    task automatic test_loopback();
        logic [7:0] d;
        logic [9:0] frameExp;
        int         a;
        bit         ok;
        obs_t       o;
        $display("[TB] loopback 0xA5");
        d        = 8'hA5;
        frameExp = {1'b1, d, 1'b0};
        loopEn   = 1'b1;
        applyStimulus(d, a, ok);
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    waitUntil(a + i * CPB + CPB / 2);
                    total++;
                    if (txPin !== frameExp[i]) begin
                        bad++;
                        $display("[TB] FAIL tx_bit%0d: got %b want %b", i, txPin, frameExp[i]);
                    end
                end
            end
            waitRsp(700, o);
        join
        loopEn = 1'b0;
        total++; if (!o.found) begin bad++; $display("[TB] FAIL loop_rsp: no rsp_valid within 700 cycles"); end
        total++; if (o.match !== 1'b1 || o.data !== d) begin bad++; $display("[TB] FAIL loop_result: got match=%b data=%h want match=1 data=%h", o.match, o.data, d); end
        total++; if (o.readyAt !== 1'b0 || o.readyNext !== 1'b1) begin bad++; $display("[TB] FAIL loop_ready: got at=%b next=%b want 0/1", o.readyAt, o.readyNext); end
    endtask

    task automatic test_mismatch();
        obs_t o;
        $display("[TB] echo 0x3C for sent 0xC3");
        runEcho(8'hC3, 1'b1, 8'h3C, 1'b1, 60, 0, o);
        errExp++;
        total++; if (!o.found) begin bad++; $display("[TB] FAIL mism_rsp: no rsp_valid"); end
        total++; if ({o.match, o.fe, o.to} !== 3'b000 || o.data !== 8'h3C) begin bad++; $display("[TB] FAIL mism_result: got flags=%b%b%b data=%h want 000 data=3c", o.match, o.fe, o.to, o.data); end
        total++; if (o.err !== expErr(errExp)) begin bad++; $display("[TB] FAIL mism_err_count: got %0d want %0d", o.err, expErr(errExp)); end
    endtask

    task automatic test_timeout();
        obs_t o;
        $display("[TB] no echo, timeout");
        runEcho(8'h81, 1'b0, 8'h00, 1'b1, 0, 0, o);
        errExp++;
        total++; if (!o.found) begin bad++; $display("[TB] FAIL to_rsp: no rsp_valid"); end
        total++; if (o.lat !== SEND_CYCLES + TIMEOUT_CYCLES) begin bad++; $display("[TB] FAIL to_latency: got %0d want %0d", o.lat, SEND_CYCLES + TIMEOUT_CYCLES); end
        total++; if ({o.match, o.fe, o.to} !== 3'b001 || o.data !== 8'h00) begin bad++; $display("[TB] FAIL to_result: got flags=%b%b%b data=%h want 001 data=00", o.match, o.fe, o.to, o.data); end
        total++; if (o.err !== expErr(errExp)) begin bad++; $display("[TB] FAIL to_err_count: got %0d want %0d", o.err, expErr(errExp)); end
    endtask

    task automatic test_frame_err();
        obs_t o;
        $display("[TB] echo 0x55 with low stop bit");
        runEcho(8'h55, 1'b1, 8'h55, 1'b0, 110, 0, o);
        errExp++;
        total++; if (!o.found) begin bad++; $display("[TB] FAIL fe_rsp: no rsp_valid"); end
        total++; if ({o.match, o.fe, o.to} !== 3'b010) begin bad++; $display("[TB] FAIL fe_flags: got %b%b%b want 010", o.match, o.fe, o.to); end
        total++; if (o.err !== expErr(errExp)) begin bad++; $display("[TB] FAIL fe_err_count: got %0d want %0d", o.err, expErr(errExp)); end
    endtask

    task automatic test_glitch();
        obs_t o;
        $display("[TB] 4-cycle glitch then echo 0x11");
        runEcho(8'h11, 1'b1, 8'h11, 1'b1, 140, 115, o);
        total++; if (!o.found) begin bad++; $display("[TB] FAIL glitch_rsp: no rsp_valid"); end
        total++; if ({o.match, o.fe, o.to} !== 3'b100 || o.data !== 8'h11) begin bad++; $display("[TB] FAIL glitch_result: got flags=%b%b%b data=%h want 100 data=11", o.match, o.fe, o.to, o.data); end
    endtask

    task automatic test_unsolicited();
        int seen;
        int notReady;
        $display("[TB] unsolicited byte while idle");
        seen = 0;
        notReady = 0;
        fork
            driveEcho(8'h77, 1'b1, cyc + 2);
            begin
                for (int i = 0; i < 120; i++) begin
                    @(negedge clk);
                    if (bus.rsp_valid !== 1'b0) seen++;
                    if (bus.tx_ready !== 1'b1) notReady++;
                end
            end
        join
        total++; if (seen != 0) begin bad++; $display("[TB] FAIL unsol_rsp: got %0d rsp_valid cycles want 0", seen); end
        total++; if (notReady != 0) begin bad++; $display("[TB] FAIL unsol_ready: got %0d not-ready cycles want 0", notReady); end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        $display("[TB] tx_valid held across REPORT");
        loopEn       = 1'b1;
        bus.tx_data  = 8'h5A;
        bus.tx_valid = 1'b1;
        waitRsp(400, o);
        bus.tx_data = 8'h96;
        total++; if (!o.found || o.match !== 1'b1 || o.data !== 8'h5A) begin bad++; $display("[TB] FAIL b2b_first: got found=%b match=%b data=%h want 1/1/5a", o.found, o.match, o.data); end
        total++; if (o.readyAt !== 1'b0 || o.readyNext !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready: got at=%b next=%b want 0/1", o.readyAt, o.readyNext); end
        @(negedge clk);
        bus.tx_valid = 1'b0;
        total++; if (txPin !== 1'b0 || bus.tx_ready !== 1'b0) begin bad++; $display("[TB] FAIL b2b_second_accept: got tx=%b ready=%b want 0/0", txPin, bus.tx_ready); end
        waitRsp(400, o);
        total++; if (!o.found || o.match !== 1'b1 || o.data !== 8'h96) begin bad++; $display("[TB] FAIL b2b_second: got found=%b match=%b data=%h want 1/1/96", o.found, o.match, o.data); end
        loopEn = 1'b0;
    endtask

    task automatic test_random();
        obs_t       o;
        logic [7:0] sent;
        logic [7:0] echo;
        logic [2:0] flagsExp;
        logic [7:0] dataExp;
        int         mode;
        int         off;
        int         lo;
        int         hi;
        $display("[TB] randomized transactions");
        for (int n = 0; n < 8; n++) begin
            sent = 8'($urandom);
            mode = int'($urandom_range(0, 3));
            off  = int'($urandom_range(40, 180));
            echo = sent;
            if (mode == 1) echo = sent ^ 8'($urandom_range(1, 255));
            if (mode == 2) echo = 8'($urandom);
            runEcho(sent, mode != 3, echo, (mode == 2) ? 1'b0 : 1'b1, off, 0, o);
            case (mode)
                0:       begin flagsExp = 3'b100; dataExp = sent; end
                1:       begin flagsExp = 3'b000; dataExp = echo; end
                2:       begin flagsExp = 3'b010; dataExp = echo; end
                default: begin flagsExp = 3'b001; dataExp = 8'h00; end
            endcase
            if (mode != 0) errExp++;
            total++;
            if (!o.found || {o.match, o.fe, o.to} !== flagsExp || o.data !== dataExp) begin
                bad++;
                $display("[TB] FAIL rand%0d_result: got found=%b flags=%b%b%b data=%h want flags=%b data=%h",
                         n, o.found, o.match, o.fe, o.to, o.data, flagsExp, dataExp);
            end
            if (mode == 3) begin
                lo = SEND_CYCLES + TIMEOUT_CYCLES;
                hi = lo;
            end else begin
                lo = (off + 9 * CPB + CPB / 2 > SEND_CYCLES + 1) ? off + 9 * CPB + CPB / 2 : SEND_CYCLES + 1;
                hi = (off + 10 * CPB + 3 > SEND_CYCLES + 2) ? off + 10 * CPB + 3 : SEND_CYCLES + 2;
            end
            total++;
            if (o.lat < lo || o.lat > hi) begin
                bad++;
                $display("[TB] FAIL rand%0d_latency: got %0d want %0d..%0d", n, o.lat, lo, hi);
            end
            total++;
            if (o.err !== expErr(errExp) || o.readyNext !== 1'b1) begin
                bad++;
                $display("[TB] FAIL rand%0d_after: got err=%0d ready=%b want err=%0d ready=1", n, o.err, o.readyNext, expErr(errExp));
            end
        end
    endtask

    task automatic test_reset_midframe();
        int  a;
        bit  ok;
        int  seen;
        int  txLow;
        $display("[TB] reset during bit 3 of send");
        applyStimulus(8'h00, a, ok);
        waitUntil(a + 4 * CPB + CPB / 2);
        total++; if (txPin !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_pre_tx: got %b want 0", txPin); end
        rst = 1'b1;
        #1;
        total++; if (txPin !== 1'b1 || bus.tx_ready !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_async: got tx=%b ready=%b want 1/0", txPin, bus.tx_ready); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        errExp = 0;
        seen = 0;
        txLow = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) seen++;
            if (txPin !== 1'b1) txLow++;
        end
        total++; if (seen != 0 || txLow != 0) begin bad++; $display("[TB] FAIL rstmid_quiet: got rsp=%0d txlow=%0d want 0/0", seen, txLow); end
        total++; if (bus.tx_ready !== 1'b1 || errCount !== expErr(errExp)) begin bad++; $display("[TB] FAIL rstmid_after: got ready=%b err=%0d want 1/%0d", bus.tx_ready, errCount, expErr(errExp)); end
    endtask

    initial begin
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        test_reset();
        test_loopback();
        test_mismatch();
        test_timeout();
        test_frame_err();
        test_glitch();
        test_unsolicited();
        test_back_to_back();
        test_random();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/uart_echo_host.md
# uart_echo_host

Initiator end of the UART echo link: accepts a byte on a valid/ready interface, serializes it (1 start, 8 data LSB-first, 1 stop), then receives the echoed byte from the far-end echo transceiver and compares it against what was sent. It issues one response per transaction: match, mismatch, framing error, or timeout. It sits in the test/bring-up path as the host-side partner of the echo device and also serves as a link-integrity checker.

## Interface
- CLK_FREQ, 50_000_000, clock frequency in Hz
- BAUD_RATE, 115_200, line rate; CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer division)
- TIMEOUT_BITS, 20, echo timeout in bit periods after own stop bit ends
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  reset; asynchronous, active-high
- tx_data  in  8  byte to send
- tx_valid  in  1  request; byte accepted when tx_valid && tx_ready
- tx_ready  out  1  high only in IDLE
- tx  out  1  serial line out, idle high
- rx  in  1  serial line in (asynchronous, from echo device)
- rsp_valid  out  1  one-cycle response pulse
- rsp_data  out  8  received byte (0x00 on timeout)
- rsp_match  out  1  received byte == sent byte and stop bit valid
- rsp_frame_err  out  1  stop bit sampled low
- rsp_timeout  out  1  no echo within timeout
- err_count  out  16  saturating count of non-match responses (see Configuration)

## Operation
- Reset values: tx=1, tx_ready=0 during reset then 1 in IDLE, all rsp_* =0, err_count=0.
- FSM states: IDLE -> SEND -> WAIT_ECHO -> REPORT -> IDLE.
- IDLE: tx_ready=1; on accept latch tx_data, arm receiver, go SEND.
- SEND: start bit (0), bits 0..7, stop bit (1), each held exactly CLKS_PER_BIT cycles; then WAIT_ECHO, timeout counter cleared.
- Receiver: rx passed through 2-flop synchronizer; armed from accept onward. Falling edge (synced rx=0) starts frame; re-sampled at CLKS_PER_BIT/2; if high, false start, receiver returns to hunt. Data sampled every CLKS_PER_BIT thereafter, LSB first; stop sampled one period after bit 7.
- WAIT_ECHO: timeout counter increments each cycle while receiver is hunting; frozen while a frame is in progress. Frame completion -> REPORT with data/flags. Counter reaching TIMEOUT_BITS*CLKS_PER_BIT with receiver hunting -> REPORT with timeout.
- REPORT: single cycle; rsp_valid=1 with exactly one of {rsp_match, mismatch (all flags 0), rsp_frame_err, rsp_timeout}; next cycle IDLE.
- Receiver disarmed in IDLE: bytes arriving unsolicited are ignored.

## Timing
- Accept at edge N -> tx low from N+1; stop bit ends at N+1+10*CLKS_PER_BIT.
- Echo frame completion at cycle M -> rsp_valid at M+1; tx_ready at M+2.
- Sync latency: 2 cycles from rx pin to start detect.
- Simultaneous frame completion and timeout expiry: frame wins (no timeout).
- Echo starting before own stop bit ends: still captured (receiver armed at accept).
- tx_valid held high across REPORT: next accept occurs in IDLE, never in REPORT.
- Reset mid-frame: tx forced high asynchronously, FSM to IDLE, no rsp_valid.

## Configuration
- UART_ECHO_HOST_STATS_EN defined: err_count increments on every rsp_valid without rsp_match, saturates at 0xFFFF, cleared only by rst.
- Undefined: counter logic omitted, err_count tied to 0; all other behaviour identical.

## Structure
- Shared package uart_pkg: clks_per_bit function, host FSM state enum, frame constants (DATA_BITS=8, STOP_BITS=1).
- One sub-module: uart_rx_core (synchronizer + deserializer, outputs byte, done pulse, frame_err, busy); the echo device may reuse it later.

## Test plan
All with CLK_FREQ=1_000_000, BAUD_RATE=100_000 (CLKS_PER_BIT=10), TIMEOUT_BITS=20.
- Loopback tx->rx, send 0xA5 -> tx frame 0,1,0,1,0,0,1,0,1,1 at 10 cycles/bit; rsp_match=1, rsp_data=0xA5.
- Model echoes 0x3C for sent 0xC3 -> rsp_valid with all flags 0, rsp_data=0x3C, err_count=1 (STATS_EN).
- rx held high after send -> rsp_timeout=1 exactly 200 cycles after stop bit ends, rsp_data=0x00.
- Echo 0x55 with stop bit low -> rsp_frame_err=1, rsp_match=0.
- 4-cycle low glitch on rx in WAIT_ECHO then real echo 0x11 -> glitch rejected, rsp_match=1.
- rst asserted at bit 3 of send -> tx=1 immediately, no rsp_valid, tx_ready=1 after release.
